// File: rtl/ctrl_types_pkg.sv
// Shared controller types: sub-command status, GET sub-FSM states and a
// one-hot validity helper used by the get/upsert/delete paths.
package ctrl_types_pkg;

   // Widest index vector the one-hot helper accepts; callers zero-extend.
   localparam int MAX_ENTRIES = 64;

   typedef struct packed {
      logic done;
      logic error;
   } sub_cmd_t;

   typedef enum logic [1:0] {
      GET_ST_IDLE  = 2'd0,
      GET_ST_START = 2'd1,
      GET_ST_WAIT  = 2'd2,
      GET_ST_RESP  = 2'd3
   } get_substate_e;

   // True when exactly one bit of v is set.
   function automatic logic is_onehot(input logic [MAX_ENTRIES-1:0] v);
      return (v != '0) && ((v & (v - MAX_ENTRIES'(1))) == '0);
   endfunction

endpackage

// File: rtl/get_fsm.sv
// Read-side GET sub-FSM: validates a comparator hit, reads the entry over a
// fixed-latency port and returns it by valid/ready. Option: GET_TOUCH_EN.
module get_fsm
   import ctrl_types_pkg::*;
#(
   parameter int NUM_ENTRIES  = 16,
   parameter int VALUE_WIDTH  = 32,
   parameter int READ_LATENCY = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   enter,
   input  logic                   hit,
   input  logic [NUM_ENTRIES-1:0] used,
   input  logic [NUM_ENTRIES-1:0] idx_in,
   input  logic [VALUE_WIDTH-1:0] data_in,
   input  logic                   resp_ready_in,
   output logic                   select_out,
   output logic                   read_out,
   output logic [NUM_ENTRIES-1:0] idx_out,
   output logic [VALUE_WIDTH-1:0] value_out,
   output logic                   rdy_out,
   output logic                   op_succ,
`ifdef GET_TOUCH_EN
   output logic [NUM_ENTRIES-1:0] touch_out,
`endif
   output sub_cmd_t               cmd
);

   localparam int CNT_W = 4;

   get_substate_e          state, state_nx;
   logic [CNT_W-1:0]       cnt, cnt_nx;
   logic [NUM_ENTRIES-1:0] idx_q, idx_nx;
   logic [VALUE_WIDTH-1:0] value_q, value_nx;
   logic                   valid_hit;
   logic                   xfer;

   assign valid_hit = hit && is_onehot(MAX_ENTRIES'(idx_in)) && ((idx_in & used) != '0);

   // enter only redirects the state; datapath registers advance on plain en cycles.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= GET_ST_IDLE;
         cnt     <= '0;
         idx_q   <= '0;
         value_q <= '0;
      end else if (enter) begin
         state   <= GET_ST_START;
      end else if (en) begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         idx_q   <= idx_nx;
         value_q <= value_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      idx_nx     = idx_q;
      value_nx   = value_q;
      select_out = 1'b0;
      read_out   = 1'b0;
      idx_out    = '0;
      rdy_out    = 1'b0;
      op_succ    = 1'b0;
      xfer       = 1'b0;
      cmd        = '0;
      value_out  = value_q;
      case (state)
         GET_ST_IDLE: ;
         GET_ST_START: begin
            if (valid_hit) begin
               idx_nx   = idx_in;
               cnt_nx   = CNT_W'(READ_LATENCY - 1);
               state_nx = GET_ST_WAIT;
            end else begin
               // A hit that fails validation is reported as an error.
               cmd.done  = 1'b1;
               cmd.error = hit;
               state_nx  = GET_ST_IDLE;
            end
         end
         GET_ST_WAIT: begin
            select_out = 1'b1;
            read_out   = 1'b1;
            idx_out    = idx_q;
            if (cnt == '0) begin
               value_nx = data_in;
               state_nx = GET_ST_RESP;
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end
         GET_ST_RESP: begin
            rdy_out = 1'b1;
            op_succ = 1'b1;
            xfer    = en && resp_ready_in;
            if (xfer) begin
               cmd.done = 1'b1;
               state_nx = GET_ST_IDLE;
            end
         end
         default: state_nx = GET_ST_IDLE;
      endcase
   end

`ifdef GET_TOUCH_EN
   assign touch_out = xfer ? idx_q : '0;
`endif

endmodule

// File: doc/get_fsm.md
# get_fsm

Read-side sub-FSM of the cache controller, complementing the upsert path. When the controller dispatches a GET, this block checks the key-match result from the comparator array. On a valid hit it reads the selected entry over a fixed-latency memory port and returns the value to the requester through a valid/ready handshake. It then reports completion or error to the top-level controller through the shared sub-command status.

## Interface
Parameters:
- NUM_ENTRIES, 16, number of cache entries; width of one-hot index vectors
- VALUE_WIDTH, 32, width of stored value
- READ_LATENCY, 2, cycles from read_out assertion to valid data_in; legal range 1..15

Ports:
- clk  in  1  clock; one clock domain
- rst_n  in  1  reset; synchronous, active-low
- en  in  1  advance enable; state and counter hold when low
- enter  in  1  (re)start GET; forces state to GET_ST_START; priority over en
- hit  in  1  key found by comparator array
- used  in  NUM_ENTRIES  entry-occupied flags
- idx_in  in  NUM_ENTRIES  one-hot match index from comparator
- data_in  in  VALUE_WIDTH  value memory read data
- resp_ready_in  in  1  requester accepts value
- select_out  out  1  value memory select
- read_out  out  1  value memory read strobe
- idx_out  out  NUM_ENTRIES  one-hot entry being read
- value_out  out  VALUE_WIDTH  registered read value
- rdy_out  out  1  value_out valid
- op_succ  out  1  GET returned data
- cmd  out  ctrl_types_pkg::sub_cmd_t  done/error status to controller

## Operation
- State register priority: !rst_n, then enter, then en. Everything else is combinational from state and registers.
- Defaults in every state: all outputs 0, cmd.done=0, cmd.error=0.
- GET_ST_IDLE: outputs at defaults; waits for enter.
- GET_ST_START evaluates:
  - valid hit: hit=1, idx_in exactly one-hot, (idx_in & used)≠0. Latch idx_in into idx_q, load cnt=READ_LATENCY-1, go to GET_ST_WAIT.
  - miss: hit=0. cmd.done=1, error=0, op_succ=0; go to GET_ST_IDLE.
  - corrupt hit: hit=1 but idx_in zero, multi-hot, or pointing to an unused entry. cmd.done=1, error=1; go to GET_ST_IDLE.
- GET_ST_WAIT: select_out=1, read_out=1, idx_out=idx_q.
  - cnt decrements on each en cycle.
  - On an en cycle with cnt==0: capture data_in into value_q and go to GET_ST_RESP.
- GET_ST_RESP: rdy_out=1, op_succ=1, value_out=value_q.
  - On en && resp_ready_in: cmd.done=1 in the same cycle, then go to GET_ST_IDLE.
  - value_q holds until the next capture.
- value_out always shows value_q; consumers qualify it with rdy_out.

## Timing
- Reset values: state GET_ST_IDLE, idx_q=0, value_q=0, cnt=0. All outputs are 0 after reset.
- Latency with en held high:
  - enter in cycle 0 puts the block in START in cycle 1.
  - Read strobe is asserted for READ_LATENCY cycles (cycles 2..1+READ_LATENCY).
  - rdy_out rises in cycle 2+READ_LATENCY.
- Miss and error complete with cmd.done in cycle 1 (one cycle in START).
- Handshake: the transfer completes when rdy_out && resp_ready_in && en. rdy_out and value_out stay stable until the transfer completes.
- en low: state, cnt and value_q freeze. Outputs keep reflecting the frozen state, so read_out stays asserted during WAIT.
- enter during WAIT or RESP aborts the current GET. The next cycle is START, and no cmd.done is issued for the aborted GET.
- enter and resp_ready_in in the same RESP cycle: enter wins. cmd.done is still asserted combinationally that cycle. The controller must not pulse enter in a completing cycle.
- rst_n low mid-operation returns to IDLE on the next edge. Any read in flight is dropped.

## Configuration
- GET_TOUCH_EN defined:
  - Adds output port touch_out [NUM_ENTRIES], for recency/LRU tracking.
  - touch_out pulses idx_q for exactly one cycle, the cycle in which the RESP transfer completes. It is 0 otherwise and 0 on reset.
- GET_TOUCH_EN undefined: the port and its logic are absent. Behaviour is otherwise identical.

## Structure
- ctrl_types_pkg gains enum get_substate_e with values GET_ST_IDLE, GET_ST_START, GET_ST_WAIT, GET_ST_RESP.
- Reuse the existing sub_cmd_t; no new struct is needed.
- The one-hot validity check (exactly one bit set) goes in the package as a function, for sharing with upsert/delete paths.
- No sub-module; the single FSM plus counter is sufficient.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with enter=1 → state IDLE, all outputs 0, value_out=0.
- Hit, READ_LATENCY=2: hit=1, idx_in=16'h0008, used=16'h000F, data_in=32'hDEADBEEF, resp_ready_in=1 → read_out high with idx_out=0x0008 for 2 cycles, then rdy_out=1, value_out=DEADBEEF, op_succ=1 and cmd.done=1 in the same cycle.
- Miss: hit=0 → cmd.done=1, error=0, op_succ=0 one cycle after enter; read_out never asserts.
- Corrupt hit: hit=1 with idx_in=0x0003, then idx_in=0x0010 with used=0x000F → cmd.done=1, error=1 each time; no read.
- Backpressure/stall: resp_ready_in=0 for 5 cycles, and en=0 for 3 cycles during WAIT → rdy_out and value_out stable, no cmd.done until the transfer completes; total WAIT length extended by exactly 3 cycles.
- Abort plus touch: enter pulsed during WAIT → restart in START with no cmd.done for the aborted GET. With GET_TOUCH_EN, a completed hit gives a single-cycle touch_out=idx.
